tap_controller: RTL and testbench

IEEE 1149.1-style TAP controller and instruction register that generates the boundary-scan control strobes for the two-chip scan chain. It replaces direct `extest`/`intest` pin control with a TMS-driven 16-state TAP FSM and a 4-bit instruction register holding one 2-bit instruction per chip. It sits directly upstream of `chip_1`/`chip_2`, drives their `shift_dr*`, `up_enable*`, `mode*`, `sel*` and `bp_shift*` inputs, and multiplexes the returning chain data onto `tdo`.

---
 rtl/jtag_pkg.sv | 36 +++
 rtl/tap_fsm.sv | 47 ++++
 rtl/tap_controller.sv | 86 ++++++++
 tb/tb_tap_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared constants for the boundary-scan TAP controller: state codes, instruction
// codes and IR sizing.
package jtag_pkg;

   localparam int unsigned IR_W = 4;

   localparam logic [3:0] ST_TLR   = 4'hF;
   localparam logic [3:0] ST_RTI   = 4'hC;
   localparam logic [3:0] ST_SELDR = 4'h7;
   localparam logic [3:0] ST_CAPDR = 4'h6;
   localparam logic [3:0] ST_SHDR  = 4'h2;
   localparam logic [3:0] ST_EX1DR = 4'h1;
   localparam logic [3:0] ST_PAUDR = 4'h3;
   localparam logic [3:0] ST_EX2DR = 4'h0;
   localparam logic [3:0] ST_UPDDR = 4'h5;
   localparam logic [3:0] ST_SELIR = 4'h4;
   localparam logic [3:0] ST_CAPIR = 4'hE;
   localparam logic [3:0] ST_SHIR  = 4'hA;
   localparam logic [3:0] ST_EX1IR = 4'h9;
   localparam logic [3:0] ST_PAUIR = 4'hB;
   localparam logic [3:0] ST_EX2IR = 4'h8;
   localparam logic [3:0] ST_UPDIR = 4'hD;

   localparam logic [1:0] INSTR_EXTEST = 2'b00;
   localparam logic [1:0] INSTR_INTEST = 2'b01;
   localparam logic [1:0] INSTR_SAMPLE = 2'b10;
   localparam logic [1:0] INSTR_BYPASS = 2'b11;

   localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

   // EXTEST and INTEST drive the chip's boundary cells in test mode.
   function automatic logic is_test_mode(input logic [1:0] code);
      return (code == INSTR_EXTEST) || (code == INSTR_INTEST);
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state register and TMS-driven next-state logic.
module tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       rst,
   input  logic       tms,
   output logic [3:0] tap_state
);

   logic [3:0] state_q;
   logic [3:0] state_d;

   always_comb begin
      state_d = ST_TLR;
      unique case (state_q)
         ST_TLR:   state_d = tms ? ST_TLR   : ST_RTI;
         ST_RTI:   state_d = tms ? ST_SELDR : ST_RTI;
         ST_SELDR: state_d = tms ? ST_SELIR : ST_CAPDR;
         ST_CAPDR: state_d = tms ? ST_EX1DR : ST_SHDR;
         ST_SHDR:  state_d = tms ? ST_EX1DR : ST_SHDR;
         ST_EX1DR: state_d = tms ? ST_UPDDR : ST_PAUDR;
         ST_PAUDR: state_d = tms ? ST_EX2DR : ST_PAUDR;
         ST_EX2DR: state_d = tms ? ST_UPDDR : ST_SHDR;
         ST_UPDDR: state_d = tms ? ST_SELDR : ST_RTI;
         ST_SELIR: state_d = tms ? ST_TLR   : ST_CAPIR;
         ST_CAPIR: state_d = tms ? ST_EX1IR : ST_SHIR;
         ST_SHIR:  state_d = tms ? ST_EX1IR : ST_SHIR;
         ST_EX1IR: state_d = tms ? ST_UPDIR : ST_PAUIR;
         ST_PAUIR: state_d = tms ? ST_EX2IR : ST_PAUIR;
         ST_EX2IR: state_d = tms ? ST_UPDIR : ST_SHIR;
         ST_UPDIR: state_d = tms ? ST_SELDR : ST_RTI;
         default:  state_d = ST_TLR;
      endcase
   end

   always_ff @(posedge tck) begin
      if (!rst) begin
         state_q <= ST_TLR;
      end else begin
         state_q <= state_d;
      end
   end

   assign tap_state = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: instruction register, per-chip instruction decode into
// boundary-scan strobes, and the registered tdo mux.
module tap_controller
   import jtag_pkg::*;
(
   input  logic            tck,
   input  logic            rst,
   input  logic            tms,
   input  logic            tdi,
   input  logic            chain_tdo,
   output logic            tdo,
   output logic [3:0]      tap_state,
   output logic [IR_W-1:0] ir_value,
   output logic            capture_dr,
   output logic            shift_dr1,
   output logic            up_enable1,
   output logic            mode1,
   output logic            sel1,
   output logic            bp_shift1,
   output logic            shift_dr2,
   output logic            up_enable2,
   output logic            mode2,
   output logic            sel2,
   output logic            bp_shift2
);

   logic [IR_W-1:0] ir_sh_q;
   logic [IR_W-1:0] ir_value_q;
   logic            tdo_q;
   logic [1:0]      code1;
   logic [1:0]      code2;
   logic            in_shdr;
   logic            in_upddr;

   tap_fsm u_tap_fsm (
      .tck       (tck),
      .rst       (rst),
      .tms       (tms),
      .tap_state (tap_state)
   );

   always_ff @(posedge tck) begin
      if (!rst) begin
         ir_sh_q    <= IR_CAPTURE;
         ir_value_q <= '1;
         tdo_q      <= 1'b0;
      end else begin
         tdo_q <= 1'b0;
         case (tap_state)
            ST_CAPIR: ir_sh_q <= IR_CAPTURE;
            ST_SHIR: begin
               tdo_q   <= ir_sh_q[0];
               ir_sh_q <= {tdi, ir_sh_q[IR_W-1:1]};
            end
            ST_UPDIR: ir_value_q <= ir_sh_q;
            ST_TLR:   ir_value_q <= '1;
            ST_SHDR:  tdo_q <= chain_tdo;
            default:  ;
         endcase
      end
   end

   assign tdo      = tdo_q;
   assign ir_value = ir_value_q;

   // Strobes decode straight from the registered state so they are valid on entry.
   assign code1    = ir_value_q[1:0];
   assign code2    = ir_value_q[3:2];
   assign in_shdr  = (tap_state == ST_SHDR);
   assign in_upddr = (tap_state == ST_UPDDR);

   assign capture_dr = (tap_state == ST_CAPDR);

   assign shift_dr1  = in_shdr && (code1 != INSTR_BYPASS);
   assign bp_shift1  = in_shdr && (code1 == INSTR_BYPASS);
   assign up_enable1 = in_upddr && is_test_mode(code1);
   assign mode1      = is_test_mode(code1);
   assign sel1       = (code1 == INSTR_BYPASS);

   assign shift_dr2  = in_shdr && (code2 != INSTR_BYPASS);
   assign bp_shift2  = in_shdr && (code2 == INSTR_BYPASS);
   assign up_enable2 = in_upddr && is_test_mode(code2);
   assign mode2      = is_test_mode(code2);
   assign sel2       = (code2 == INSTR_BYPASS);

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: TMS walks through IR and DR scans with
// hand-computed expectations for state, IR, tdo and strobes.
module tb_tap_controller;

   logic       tck = 1'b0;
   logic       rst = 1'b0;
   logic       tms = 1'b1;
   logic       tdi = 1'b0;
   logic       chain_tdo = 1'b0;
   logic       tdo;
   logic [3:0] tap_state;
   logic [3:0] ir_value;
   logic       capture_dr;
   logic       shift_dr1, up_enable1, mode1, sel1, bp_shift1;
   logic       shift_dr2, up_enable2, mode2, sel2, bp_shift2;

   int n_cmp = 0;
   int n_err = 0;

   tap_controller dut (
      .tck        (tck),
      .rst        (rst),
      .tms        (tms),
      .tdi        (tdi),
      .chain_tdo  (chain_tdo),
      .tdo        (tdo),
      .tap_state  (tap_state),
      .ir_value   (ir_value),
      .capture_dr (capture_dr),
      .shift_dr1  (shift_dr1),
      .up_enable1 (up_enable1),
      .mode1      (mode1),
      .sel1       (sel1),
      .bp_shift1  (bp_shift1),
      .shift_dr2  (shift_dr2),
      .up_enable2 (up_enable2),
      .mode2      (mode2),
      .sel2       (sel2),
      .bp_shift2  (bp_shift2)
   );

   always #5 tck = ~tck;

   task automatic step(input logic t, input logic d, input logic c);
      tms       = t;
      tdi       = d;
      chain_tdo = c;
      @(posedge tck);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ctrls();
      return {capture_dr, shift_dr1, shift_dr2, up_enable1, up_enable2,
              mode1, mode2, bp_shift1, bp_shift2};
   endfunction

   initial begin
      // 1. reset
      rst = 1'b0;
      step(1, 0, 0);
      chk("rst_state", 9'(tap_state), 9'hF);
      chk("rst_ir", 9'(ir_value), 9'hF);
      chk("rst_tdo", 9'(tdo), 9'h0);
      chk("rst_sel", 9'({sel1, sel2}), 9'b11);
      chk("rst_ctrls", ctrls(), 9'h0);
      rst = 1'b1;

      // 2. park in ShDR then five tms=1
      step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      chk("park_shdr", 9'(tap_state), 9'h2);
      chk("park_bp", 9'({shift_dr1, bp_shift1, bp_shift2}), 9'b011);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      chk("tms5_state", 9'(tap_state), 9'hF);
      chk("tms5_ir", 9'(ir_value), 9'hF);

      // 3. IR scan shifting 0,0,1,1
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      chk("shir_state", 9'(tap_state), 9'hA);
      step(0, 0, 0); chk("ir_tdo0", 9'(tdo), 9'h1);
      step(0, 0, 0); chk("ir_tdo1", 9'(tdo), 9'h0);
      step(0, 1, 0); chk("ir_tdo2", 9'(tdo), 9'h1);
      step(1, 1, 0); chk("ir_tdo3", 9'(tdo), 9'h0);
      chk("ex1ir_state", 9'(tap_state), 9'h9);
      step(1, 0, 0);
      chk("updir_state", 9'(tap_state), 9'hD);
      chk("updir_ir_old", 9'(ir_value), 9'hF);
      step(0, 0, 0);
      chk("ir_1100", 9'(ir_value), 9'hC);
      chk("ir_dec", 9'({mode1, sel1, mode2, sel2}), 9'b1001);

      // 4/5. DR scan with IR=1100
      step(1, 0, 0);
      chk("seldr_cap", 9'(capture_dr), 9'h0);
      step(0, 0, 0);
      chk("capdr_state", 9'(tap_state), 9'h6);
      chk("capdr_pulse", 9'(capture_dr), 9'h1);
      step(0, 0, 0);
      chk("shdr_ctrls", ctrls(), 9'b0_10_00_10_01);
      step(0, 0, 1); chk("dr_tdo0", 9'(tdo), 9'h1);
      step(0, 0, 1); chk("dr_tdo1", 9'(tdo), 9'h1);
      step(0, 0, 0); chk("dr_tdo2", 9'(tdo), 9'h0);
      step(1, 0, 1); chk("dr_tdo3", 9'(tdo), 9'h1);
      chk("ex1dr_ctrls", ctrls(), 9'b0_00_00_10_00);
      step(1, 0, 1);
      chk("upd_tdo", 9'(tdo), 9'h0);
      chk("upd_en", 9'({up_enable1, up_enable2}), 9'b10);
      step(0, 0, 0);
      chk("upd_en_off", 9'({up_enable1, up_enable2}), 9'b00);

      // TLR reloads BYPASS on the edge taken in TLR
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      chk("tlr_state", 9'(tap_state), 9'hF);
      chk("tlr_ir_held", 9'(ir_value), 9'hC);
      step(1, 0, 0);
      chk("tlr_ir_f", 9'(ir_value), 9'hF);

      // 6. reset in the middle of an IR shift
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 1, 0); step(0, 1, 0);
      rst = 1'b0;
      step(1, 0, 0);
      chk("mid_rst_state", 9'(tap_state), 9'hF);
      chk("mid_rst_ir", 9'(ir_value), 9'hF);
      chk("mid_rst_tdo", 9'(tdo), 9'h0);
      rst = 1'b1;
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 1, 0); chk("re_tdo0", 9'(tdo), 9'h1);
      step(0, 0, 0); chk("re_tdo1", 9'(tdo), 9'h0);
      step(0, 1, 0); chk("re_tdo2", 9'(tdo), 9'h1);
      step(1, 1, 0); chk("re_tdo3", 9'(tdo), 9'h0);
      step(1, 0, 0); step(0, 0, 0);
      chk("ir_1101", 9'(ir_value), 9'hD);
      chk("ir_1101_dec", 9'({mode1, sel1, mode2, sel2}), 9'b1001);

      // DR scan through pause, resume without recapture
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      chk("shdr2_ctrls", ctrls(), 9'b0_10_00_10_01);
      step(1, 0, 0); step(0, 0, 0);
      chk("paudr_state", 9'(tap_state), 9'h3);
      step(1, 0, 0); step(0, 0, 0);
      chk("resume_shdr", 9'({tap_state, capture_dr}), 9'({4'h2, 1'b0}));
      step(1, 0, 0); step(1, 0, 0);
      chk("upd2_en", 9'({up_enable1, up_enable2}), 9'b10);
      step(0, 0, 0);
      chk("rti_state", 9'(tap_state), 9'hC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
